usb_tx_bit_stuffer: RTL and testbench

USB_TX_BIT_STUFFER -- requirements
Module: usb_tx_bit_stuffer

---
 rtl/usb_tx_pkg.sv | 24 ++
 rtl/usb_tx_bit_stuffer_if.sv | 25 ++
 rtl/bit_timer.sv | 35 +++
 rtl/usb_tx_bit_stuffer.sv | 163 ++++++++++++++++
 tb/tb_usb_tx_bit_stuffer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit bit stuffer.
package usb_tx_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 8;
   localparam int STUFF_LIMIT          = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STUFF = 2'd2
   } state_t;

   typedef struct packed {
      state_t     state;
      logic [3:0] bit_idx;
      logic [2:0] ones_cnt;
   } dbg_t;

   // Run length of consecutive ones after a data bit has been sent.
   function automatic logic [2:0] next_ones(input logic [2:0] ones, input logic b);
      return b ? ones + 3'd1 : 3'd0;
   endfunction

endpackage

// File: rtl/usb_tx_bit_stuffer_if.sv
// Byte-side handshake and serial-side outputs of the USB transmit bit stuffer.
interface usb_tx_bit_stuffer_if;
   // A byte moves on the rising edge where byte_valid && byte_ready; the source
   // holds byte_in/byte_last stable with byte_valid high until that edge.
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_last;
   logic       byte_ready;
   logic       bit_out;
   logic       bit_strobe;
   logic       stuff_bit;
   logic       busy;
   logic       eop_req;
   logic       underrun;

   modport master (
      output byte_in, byte_valid, byte_last,
      input  byte_ready, bit_out, bit_strobe, stuff_bit, busy, eop_req, underrun
   );

   modport slave (
      input  byte_in, byte_valid, byte_last,
      output byte_ready, bit_out, bit_strobe, stuff_bit, busy, eop_req, underrun
   );
endinterface

// File: rtl/bit_timer.sv
// Rollover counter 0..MAX-1 with synchronous clear and count enable.
module bit_timer #(
   parameter int MAX = 8
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic rollover
);

   localparam int W = $clog2(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   assign rollover = enable && (cnt_q == W'(MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = rollover ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// Serialises packet bytes LSB first at CLKS_PER_BIT clocks per bit, inserting
// a 0 after every six consecutive ones, with a one-byte holding register.
module usb_tx_bit_stuffer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                clk,
   input  logic                n_rst,
   usb_tx_bit_stuffer_if.slave bus,
   output dbg_t                dbg
);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_last_q, hold_last_d;
   logic       hold_valid_q, hold_valid_d;
   logic       cur_last_q, cur_last_d;
   logic [3:0] bit_idx_q, bit_idx_d;
   logic [2:0] ones_q, ones_d;
   logic       eop_q, eop_d;
   logic       underrun_q, underrun_d;

   logic       bit_strobe_w;
   logic       timer_run;
   logic [2:0] ones_nx;
   logic       end_byte;

   assign timer_run = (state_q != ST_IDLE);

   bit_timer #(
      .MAX(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (!timer_run),
      .enable   (timer_run),
      .rollover (bit_strobe_w)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      hold_valid_d = hold_valid_q;
      cur_last_d   = cur_last_q;
      bit_idx_d    = bit_idx_q;
      ones_d       = ones_q;
      eop_d        = 1'b0;
      underrun_d   = 1'b0;
      ones_nx      = next_ones(ones_q, shift_q[0]);
      end_byte     = 1'b0;

      // Ready is !hold_valid_q, so a write never meets an unload in one cycle.
      if (bus.byte_valid && !hold_valid_q) begin
         hold_data_d  = bus.byte_in;
         hold_last_d  = bus.byte_last;
         hold_valid_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (hold_valid_q) begin
               shift_d      = hold_data_q;
               cur_last_d   = hold_last_q;
               hold_valid_d = 1'b0;
               bit_idx_d    = 4'd0;
               ones_d       = 3'd0;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bit_strobe_w) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 4'd1;
               if (ones_nx == 3'(STUFF_LIMIT)) begin
                  ones_d  = 3'd0;
                  state_d = ST_STUFF;
               end else begin
                  ones_d   = ones_nx;
                  end_byte = (bit_idx_q == 4'd7);
               end
            end
         end
         ST_STUFF: begin
            // bit_idx of 8 means the stuff bit trails bit 7 of the byte.
            if (bit_strobe_w) begin
               if (bit_idx_q == 4'd8) begin
                  end_byte = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (end_byte) begin
         if (cur_last_q) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
         end else if (hold_valid_q) begin
            shift_d      = hold_data_q;
            cur_last_d   = hold_last_q;
            hold_valid_d = 1'b0;
            bit_idx_d    = 4'd0;
            state_d      = ST_SHIFT;
         end else begin
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= 8'd0;
         hold_data_q  <= 8'd0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         cur_last_q   <= 1'b0;
         bit_idx_q    <= 4'd0;
         ones_q       <= 3'd0;
         eop_q        <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         hold_valid_q <= hold_valid_d;
         cur_last_q   <= cur_last_d;
         bit_idx_q    <= bit_idx_d;
         ones_q       <= ones_d;
         eop_q        <= eop_d;
         underrun_q   <= underrun_d;
      end
   end

   always_comb begin
      bus.bit_out = 1'b1;
      unique case (state_q)
         ST_SHIFT: bus.bit_out = shift_q[0];
         ST_STUFF: bus.bit_out = 1'b0;
         default:  bus.bit_out = 1'b1;
      endcase
   end

   assign bus.byte_ready = !hold_valid_q;
   assign bus.bit_strobe = bit_strobe_w;
   assign bus.stuff_bit  = (state_q == ST_STUFF);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.eop_req    = eop_q;
   assign bus.underrun   = underrun_q;

   assign dbg.state    = state_q;
   assign dbg.bit_idx  = bit_idx_q;
   assign dbg.ones_cnt = ones_q;

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Directed bench for usb_tx_bit_stuffer: a packet-level bit-stuffing model
// checked every cycle, plus literal expectations for the named scenarios.
module tb_usb_tx_bit_stuffer;
   import usb_tx_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   dbg_t dbg;

   usb_tx_bit_stuffer_if bus();

   usb_tx_bit_stuffer #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus),
      .dbg   (dbg)
   );

   // clock / reset
   initial begin
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // scoreboard state
   int          n_chk = 0;
   int          n_pass = 0;
   logic [1:0]  exp_q[$];   // {stuff, bit} in transmit order
   logic [7:0]  pkt_q[$];
   bit          chk_en = 0;
   bit          term_next = 0;
   bit          term_now = 0;
   bit          term_eop = 0;
   bit          term_seen = 0;
   int          cap_cnt = 0;
   logic [31:0] cap_bits = '0;
   logic [31:0] cap_stuff = '0;
   int          eop_cnt = 0;
   int          und_cnt = 0;
   int          busy_cnt = 0;
   int          accept_cyc = 0;
   int          eop_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: the wire sequence of a packet follows from the byte list alone.
   task automatic build_model(input bit last_final);
      int ones = 0;
      foreach (pkt_q[i]) begin
         for (int k = 0; k < 8; k++) begin
            logic b;
            b = pkt_q[i][k];
            exp_q.push_back({1'b0, b});
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
               exp_q.push_back(2'b10);
               ones = 0;
            end
         end
      end
      term_eop = last_final;
   endtask

   // compare process
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            term_now  = term_next;
            term_next = 0;
            check("eop_req", bus.eop_req, term_now && term_eop);
            check("underrun", bus.underrun, term_now && !term_eop);
            if (bus.eop_req) begin
               eop_cnt++;
               eop_cyc = cyc;
            end
            if (bus.underrun) und_cnt++;
            if (term_now) term_seen = 1;
            if (!bus.busy) begin
               check("idle_bit_out", bus.bit_out, 1);
               check("idle_stuff_bit", bus.stuff_bit, 0);
               check("idle_bit_strobe", bus.bit_strobe, 0);
            end else begin
               busy_cnt++;
               if (exp_q.size() == 0) begin
                  check("busy_without_expected_bits", bus.busy, 0);
               end else begin
                  check("bit_out", bus.bit_out, exp_q[0][0]);
                  check("stuff_bit", bus.stuff_bit, exp_q[0][1]);
                  if (bus.bit_strobe) begin
                     if (cap_cnt < 32) begin
                        cap_bits[cap_cnt]  = bus.bit_out;
                        cap_stuff[cap_cnt] = bus.stuff_bit;
                     end
                     cap_cnt++;
                     void'(exp_q.pop_front());
                     if (exp_q.size() == 0) term_next = 1;
                  end
               end
            end
         end
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_test();
      cap_cnt   = 0;
      cap_bits  = '0;
      cap_stuff = '0;
      eop_cnt   = 0;
      und_cnt   = 0;
      busy_cnt  = 0;
      term_seen = 0;
      term_next = 0;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int t = 0;
      bus.byte_in    = d;
      bus.byte_last  = last;
      bus.byte_valid = 1'b1;
      while (!bus.byte_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) check("byte_accept_timeout", bus.byte_ready, 1);
      @(posedge clk);
      #1;
      accept_cyc     = cyc;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      bus.byte_in    = 8'd0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (!term_seen && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!term_seen) check("packet_end_timeout", term_seen, 1);
   endtask

   task automatic run_packet(input bit last_final);
      start_test();
      build_model(last_final);
      for (int i = 0; i < pkt_q.size(); i++) begin
         send_byte(pkt_q[i], last_final && (i == pkt_q.size() - 1));
      end
      wait_done(40 * N);
      idle(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bit_out"}, bus.bit_out, 1);
      check({tag, "_byte_ready"}, bus.byte_ready, 1);
      check({tag, "_bit_strobe"}, bus.bit_strobe, 0);
      check({tag, "_stuff_bit"}, bus.stuff_bit, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_eop_req"}, bus.eop_req, 0);
      check({tag, "_underrun"}, bus.underrun, 0);
      check({tag, "_state"}, dbg.state, ST_IDLE);
   endtask

   // main sequence
   initial begin
      int t;
      bus.byte_in    = 8'd0;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      n_rst  = 1'b1;
      chk_en = 1;
      idle(2);

      // single last 0xFF: stuff after six ones
      pkt_q = '{8'hFF};
      run_packet(1);
      check("ff_strobes", cap_cnt, 9);
      check("ff_bits", cap_bits, 32'h1BF);
      check("ff_stuff", cap_stuff, 32'h040);
      check("ff_eop_cnt", eop_cnt, 1);
      check("ff_und_cnt", und_cnt, 0);

      // single last 0x00: no stuffing, latency from accept to eop
      pkt_q = '{8'h00};
      run_packet(1);
      check("00_strobes", cap_cnt, 8);
      check("00_bits", cap_bits, 32'h0);
      check("00_stuff", cap_stuff, 32'h0);
      check("00_eop_latency", eop_cyc - accept_cyc, 8 * N + 1);

      // 0xF8 then last 0x07: ones run carries across the byte boundary
      pkt_q = '{8'hF8, 8'h07};
      run_packet(1);
      check("f807_strobes", cap_cnt, 17);
      check("f807_bits", cap_bits, 32'hDF8);
      check("f807_stuff", cap_stuff, 32'h200);
      check("f807_no_gap", busy_cnt, 17 * N);
      check("f807_eop_cnt", eop_cnt, 1);

      // non-last 0x55 with nothing behind it
      pkt_q = '{8'h55};
      run_packet(0);
      check("55_strobes", cap_cnt, 8);
      check("55_bits", cap_bits, 32'h55);
      check("55_und_cnt", und_cnt, 1);
      check("55_eop_cnt", eop_cnt, 0);
      check("55_busy_after", bus.busy, 0);
      check("55_bit_out_after", bus.bit_out, 1);

      // stuff bit trailing bit 7, then another byte
      pkt_q = '{8'hFC, 8'h01};
      run_packet(1);
      check("fc01_strobes", cap_cnt, 17);
      check("fc01_bits", cap_bits, 32'h2FC);
      check("fc01_stuff", cap_stuff, 32'h100);

      // stuff bit trailing bit 7 of the last byte
      pkt_q = '{8'hFC};
      run_packet(1);
      check("fc_strobes", cap_cnt, 9);
      check("fc_bits", cap_bits, 32'h0FC);
      check("fc_stuff", cap_stuff, 32'h100);
      check("fc_eop_cnt", eop_cnt, 1);

      // reset during bit 3 of 0xA5
      pkt_q = '{8'hA5};
      start_test();
      build_model(1);
      send_byte(8'hA5, 1'b1);
      t = 0;
      while (cap_cnt < 3 && t < 20 * N) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("a5_bits_before_reset", cap_bits, 32'h5);
      @(posedge clk);
      #2;
      chk_en = 0;
      n_rst  = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      term_next = 0;
      idle(2);
      n_rst  = 1'b1;
      chk_en = 1;
      idle(12 * N);
      check("midreset_eop_cnt", eop_cnt, 0);
      check("midreset_und_cnt", und_cnt, 0);
      check("midreset_busy", bus.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
